// File: rtl/aud_pwm_mc_if.sv
// Sample stream into the multichannel audio PWM player.
// The master drives s_valid/s_data and the player answers with s_ready.
interface aud_pwm_mc_if #(
    parameter int DATA_WIDTH = 8,
    parameter int CHANNELS   = 2
);
    logic                           s_valid;
    logic [CHANNELS*DATA_WIDTH-1:0] s_data;
    logic                           s_ready;

    modport master (output s_valid, output s_data, input s_ready);
    modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/aud_pwm_mc.sv
// Multichannel audio PWM player: a sample FIFO feeds one frame of 2^W cycles per
// sample word, with per-channel duty = sample >> vol_shift and midscale on underrun.
module aud_pwm_mc #(
    parameter int DATA_WIDTH = 8,
    parameter int CHANNELS   = 2,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clkd,
    input  logic                          resetn,
    input  logic                          start,
    input  logic                          stop,
    input  logic [2:0]                    vol_shift,
    aud_pwm_mc_if.slave                   s_if,
    output logic [CHANNELS-1:0]           aud_pwm,
    output logic                          busy,
    output logic                          underrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int SW = CHANNELS * DATA_WIDTH;
    localparam logic [DATA_WIDTH-1:0] CNT_MAX  = '1;
    localparam logic [DATA_WIDTH-1:0] MIDSCALE = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [AW:0]           DEPTH_L  = (AW+1)'(FIFO_DEPTH);

    typedef enum logic {IDLE, PLAY} stateT;

    stateT                 state_q, state_d;
    logic [DATA_WIDTH-1:0] count_q, count_d;
    logic [DATA_WIDTH-1:0] duty_q [CHANNELS];
    logic [DATA_WIDTH-1:0] duty_d [CHANNELS];
    logic                  stopPending_q, stopPending_d;

    logic [SW-1:0]         mem_q [FIFO_DEPTH];
    logic [AW-1:0]         wrPtr_q, rdPtr_q;
    logic [AW:0]           level_q;
    logic [SW-1:0]         rdWord;
    logic                  push, pop, empty, frameLoad;

    assign empty      = (level_q == '0);
    assign s_if.s_ready = (level_q != DEPTH_L);
    assign push       = s_if.s_valid && s_if.s_ready;
    assign pop        = frameLoad && !empty;
    assign rdWord     = mem_q[rdPtr_q];
    assign fifo_level = level_q;
    assign busy       = (state_q == PLAY);
    // Gated by resetn so a held start cannot flag an underrun while in reset.
    assign underrun   = frameLoad && empty && resetn;

    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        stopPending_d = stopPending_q;
        duty_d        = duty_q;
        frameLoad     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d       = PLAY;
                    count_d       = '0;
                    stopPending_d = stop;
                    frameLoad     = 1'b1;
                end
            end
            PLAY: begin
                count_d       = count_q + 1'b1;
                stopPending_d = stopPending_q | stop;
                if (count_q == CNT_MAX) begin
                    if (stopPending_q || stop) begin
                        state_d       = IDLE;
                        stopPending_d = 1'b0;
                    end else begin
                        frameLoad = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (frameLoad) begin
            for (int k = 0; k < CHANNELS; k++) begin
                duty_d[k] = empty ? MIDSCALE : (rdWord[k*DATA_WIDTH +: DATA_WIDTH] >> vol_shift);
            end
        end
    end

    always_comb begin
        aud_pwm = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            aud_pwm[k] = busy && (count_q < duty_q[k]);
        end
    end

    always_ff @(posedge clkd or negedge resetn) begin
        if (!resetn) begin
            state_q       <= IDLE;
            count_q       <= '0;
            stopPending_q <= 1'b0;
            for (int k = 0; k < CHANNELS; k++) duty_q[k] <= '0;
            wrPtr_q       <= '0;
            rdPtr_q       <= '0;
            level_q       <= '0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            stopPending_q <= stopPending_d;
            duty_q        <= duty_d;
            if (push) wrPtr_q <= wrPtr_q + 1'b1;
            if (pop)  rdPtr_q <= rdPtr_q + 1'b1;
            case ({push, pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clkd) begin
        if (push) mem_q[wrPtr_q] <= s_if.s_data;
    end
endmodule

// File: tb/tb_aud_pwm_mc.sv
// Self-checking bench for aud_pwm_mc (W=8, C=2, depth 4): a queue of expected
// per-frame duties is filled as samples are pushed and consumed as frames play.
module tb_aud_pwm_mc;
    typedef struct {int d0; int d1;} expT;

    logic       clkd = 1'b0;
    logic       resetn = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [2:0] volShift = 3'd0;
    logic [1:0] audPwm;
    logic       busy;
    logic       underrun;
    logic [2:0] fifoLevel;

    int  errorCount = 0;
    int  checkCount = 0;
    expT expQ[$];
    expT midscale = '{128, 128};

    aud_pwm_mc_if #(.DATA_WIDTH(8), .CHANNELS(2)) sIf();

    aud_pwm_mc #(.DATA_WIDTH(8), .CHANNELS(2), .FIFO_DEPTH(4)) dut (
        .clkd       (clkd),
        .resetn     (resetn),
        .start      (start),
        .stop       (stop),
        .vol_shift  (volShift),
        .s_if       (sIf),
        .aud_pwm    (audPwm),
        .busy       (busy),
        .underrun   (underrun),
        .fifo_level (fifoLevel)
    );

    always #5 clkd = ~clkd;

    task automatic checkOutput(input string tag, input int actual, input int expected);
        checkCount++;
        if (actual != expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    // Push one sample word while idle; an accepted word queues its expected duties.
    task automatic applyStimulus(input logic [7:0] ch0, input logic [7:0] ch1);
        bit accept;
        accept = (expQ.size() < 4);
        sIf.s_valid = 1'b1;
        sIf.s_data  = {ch1, ch0};
        #1;
        checkOutput("s_ready_push", int'(sIf.s_ready), int'(accept));
        @(posedge clkd); #1;
        sIf.s_valid = 1'b0;
        if (accept) expQ.push_back('{int'(ch0 >> volShift), int'(ch1 >> volShift)});
        checkOutput("fifo_level_push", int'(fifoLevel), expQ.size());
    endtask

    task automatic playFrames(input int nFrames, input bit stopWithStart);
        int  hi0, hi1;
        bit  emptyNow;
        expT cur, nxt;
        start = 1'b1;
        stop  = stopWithStart;
        #1;
        emptyNow = (expQ.size() == 0);
        checkOutput("underrun_start", int'(underrun), int'(emptyNow));
        cur = emptyNow ? midscale : expQ.pop_front();
        nxt = cur;
        @(posedge clkd); #1;
        start = 1'b0;
        stop  = 1'b0;
        checkOutput("busy_start", int'(busy), 1);
        checkOutput("fifo_level_start", int'(fifoLevel), expQ.size());
        checkOutput("s_ready_start", int'(sIf.s_ready), int'(expQ.size() < 4));
        for (int f = 0; f < nFrames; f++) begin
            hi0 = 0;
            hi1 = 0;
            for (int c = 0; c < 256; c++) begin
                hi0 += int'(audPwm[0]);
                hi1 += int'(audPwm[1]);
                if (f == nFrames - 1 && !stopWithStart && c == 10) stop = 1'b1;
                if (c == 11) stop = 1'b0;
                if (c == 255) begin
                    if (f < nFrames - 1) begin
                        emptyNow = (expQ.size() == 0);
                        checkOutput("underrun_load", int'(underrun), int'(emptyNow));
                        nxt = emptyNow ? midscale : expQ.pop_front();
                    end else begin
                        checkOutput("underrun_stop", int'(underrun), 0);
                    end
                end
                @(posedge clkd); #1;
            end
            checkOutput("high_ch0", hi0, cur.d0);
            checkOutput("high_ch1", hi1, cur.d1);
            checkOutput("fifo_level_frame", int'(fifoLevel), expQ.size());
            cur = nxt;
        end
        checkOutput("busy_end", int'(busy), 0);
        checkOutput("pwm_idle", int'(audPwm), 0);
    endtask

    initial begin
        sIf.s_valid = 1'b0;
        sIf.s_data  = '0;
        repeat (3) @(posedge clkd);
        #1 resetn = 1'b1;
        @(posedge clkd); #1;
        checkOutput("reset_pwm", int'(audPwm), 0);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_ready", int'(sIf.s_ready), 1);
        checkOutput("reset_level", int'(fifoLevel), 0);
        checkOutput("reset_underrun", int'(underrun), 0);

        volShift = 3'd0;
        applyStimulus(8'hC0, 8'h40);
        playFrames(1, 1'b0);

        applyStimulus(8'h00, 8'hFF);
        playFrames(1, 1'b0);
        volShift = 3'd1;
        applyStimulus(8'hC0, 8'hFF);
        playFrames(1, 1'b0);
        volShift = 3'd0;

        applyStimulus(8'h20, 8'hE0);
        playFrames(2, 1'b0);

        for (int i = 0; i < 5; i++) applyStimulus(8'(8'h30 + i * 8'h11), 8'(8'hA0 - i * 8'h13));
        checkOutput("full_ready", int'(sIf.s_ready), 0);
        checkOutput("full_level", int'(fifoLevel), 4);
        playFrames(2, 1'b0);
        playFrames(1, 1'b1);
        playFrames(1, 1'b0);

        applyStimulus(8'h10, 8'h20);
        applyStimulus(8'h50, 8'h60);
        start = 1'b1;
        @(posedge clkd); #1;
        start = 1'b0;
        void'(expQ.pop_front());
        repeat (100) @(posedge clkd);
        #1 resetn = 1'b0;
        #1;
        checkOutput("midreset_pwm", int'(audPwm), 0);
        checkOutput("midreset_busy", int'(busy), 0);
        checkOutput("midreset_level", int'(fifoLevel), 0);
        checkOutput("midreset_ready", int'(sIf.s_ready), 1);
        expQ.delete();
        @(posedge clkd); #1 resetn = 1'b1;
        @(posedge clkd); #1;

        applyStimulus(8'h80, 8'h01);
        playFrames(1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end
endmodule

// File: doc/aud_pwm_mc.md
AUD_PWM_MC -- requirements
Module: aud_pwm_mc

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, sample and PWM counter width (W).
REQ-002 SHALL have parameter CHANNELS, default 2, number of independent PWM outputs (C).
REQ-003 SHALL have parameter FIFO_DEPTH, default 16, sample FIFO entries; power of 2, at least 2.
REQ-004 SHALL have port clkd  input  1  PWM/system clock, all logic on the rising edge.
REQ-005 SHALL have port resetn  input  1  reset; reset resetn, asynchronous, active-low; clock clkd.
REQ-006 SHALL have port start  input  1  level; begin playback when IDLE.
REQ-007 SHALL have port stop  input  1  level; request stop at the next frame boundary.
REQ-008 SHALL have port vol_shift  input  3  attenuation, right-shift applied to each sample.
REQ-009 SHALL have port s_valid  input  1  sample word valid.
REQ-010 SHALL have port s_data  input  C*W  channel k occupies bits [k*W +: W].
REQ-011 SHALL have port s_ready  output  1  FIFO can accept a word.
REQ-012 SHALL have port aud_pwm  output  C  PWM outputs, one per channel.
REQ-013 SHALL have port busy  output  1  high while in PLAY.
REQ-014 SHALL have port underrun  output  1  one-cycle pulse on an empty-FIFO frame load.
REQ-015 SHALL have port fifo_level  output  $clog2(FIFO_DEPTH)+1  current occupancy.

Function
REQ-016 SHALL push s_data into the FIFO when s_valid && s_ready; s_ready = (level < FIFO_DEPTH).
REQ-017 SHALL implement FIFO pointers that wrap modulo FIFO_DEPTH, with no fall-through: a word pushed in cycle N is poppable from cycle N+1.
REQ-018 SHALL implement an FSM with states IDLE and PLAY only.
REQ-019 SHALL, in IDLE with start=1, load a frame and enter PLAY on the next edge.
REQ-020 SHALL run a W-bit frame counter in PLAY, counting 0..2^W-1 and then wrapping to 0; one frame per sample = 2^W cycles.
REQ-021 SHALL load a frame on the IDLE->PLAY transition and on each PLAY cycle with count == 2^W-1 when no stop is pending, and set count to 0.
REQ-022 SHALL, on frame load with the FIFO non-empty, pop one word and set duty[k] = s_word[k] >> vol_shift, with vol_shift sampled at the load.
REQ-023 SHALL, on frame load with the FIFO empty, set every duty[k] = 2^(W-1) (midscale silence) and pulse underrun high for exactly that cycle.
REQ-024 SHALL drive aud_pwm[k] = busy && (count < duty[k]): duty 0 gives always low; duty 2^W-1 gives high for 2^W-1 of 2^W cycles.
REQ-025 SHALL drive all aud_pwm outputs low in IDLE.
REQ-026 SHALL latch stop while in PLAY into stop_pending, finish the current frame, and at count == 2^W-1 enter IDLE without popping; stop_pending is then cleared.
REQ-027 SHALL ignore start in PLAY and ignore stop in IDLE.
REQ-028 SHALL, when start and stop are both high in IDLE, enter PLAY with stop_pending set, playing exactly one frame.
REQ-029 SHALL keep the FIFO accepting pushes in IDLE; FIFO contents persist across stop/start.
REQ-030 SHALL, on a simultaneous push and pop, leave fifo_level unchanged.

Reset
REQ-031 SHALL, on resetn low, immediately (asynchronously) set state=IDLE, count=0, all duty=0, stop_pending=0, and empty the FIFO.
REQ-032 SHALL hold these reset output values: aud_pwm=0, busy=0, underrun=0, fifo_level=0, s_ready=1.
REQ-033 SHALL abort a frame in progress when reset is asserted mid-frame; no sample is retained.

Verification (W=8, C=2, FIFO_DEPTH=4)
REQ-034 SHALL cover reset: after reset release -> aud_pwm=00, busy=0, s_ready=1, fifo_level=0.
REQ-035 SHALL cover basic playback: push {ch1=0x40, ch0=0xC0}, then start with vol_shift=0 -> busy=1; aud_pwm[0] high 192 of 256 cycles; aud_pwm[1] high 64 of 256.
REQ-036 SHALL cover duty extremes and volume: sample 0x00 -> always low; 0xFF -> high 255/256; 0xC0 with vol_shift=1 -> high 96/256.
REQ-037 SHALL cover underrun: one word queued then start -> at the second frame load, underrun pulses 1 cycle and both channels are high 128/256.
REQ-038 SHALL cover FIFO full: 4 pushes -> fifo_level=4, s_ready=0; a 5th s_valid is dropped; a pop restores s_ready=1 the next cycle.
REQ-039 SHALL cover stop and mid-frame reset: stop at count=10 -> frame runs to 255, then IDLE and busy=0 with fifo_level unchanged; resetn low at count=100 -> outputs low immediately and fifo_level=0.
